// File: rtl/stump_shift_left_iter.sv
// Iterative 16-bit left shifter: LSL, ROL, RLC, one bit per clock.
// Optional abort input when STUMP_SHIFT_ABORT_EN is defined.
module stump_shift_left_iter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef STUMP_SHIFT_ABORT_EN
  input  logic             abort,
`endif
  input  logic [15:0]      operand_A,
  input  logic             c_in,
  input  logic [1:0]       shift_op,
  input  logic [CNT_W-1:0] shift_count,
  output logic             busy,
  output logic             done,
  output logic [15:0]      shift_out,
  output logic             c_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_ROL  = 2'b10;
  localparam logic [1:0] OP_RLC  = 2'b11;

  state_t           state_q, state_nxt;
  logic [15:0]      a_q, a_nxt;
  logic             c_q, c_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [1:0]       op_q, op_nxt;
  logic             abort_req;
  logic             ld_shift;

`ifdef STUMP_SHIFT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign ld_shift = (shift_op != OP_NONE) &&
                    (shift_count != '0);

  always_comb begin
    state_nxt = state_q;
    a_nxt     = a_q;
    c_nxt     = c_q;
    cnt_nxt   = cnt_q;
    op_nxt    = op_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_nxt   = operand_A;
          op_nxt  = shift_op;
          // carry only seeds RLC; trivial ops report c_out = 0
          c_nxt   = ld_shift && (shift_op == OP_RLC) && c_in;
          cnt_nxt = ld_shift ? shift_count : '0;
          state_nxt = ld_shift ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        c_nxt   = a_q[15];
        cnt_nxt = cnt_q - CNT_W'(1);
        unique case (1'b1)
          (op_q == OP_LSL): a_nxt = {a_q[14:0], 1'b0};
          (op_q == OP_ROL): a_nxt = {a_q[14:0], a_q[15]};
          (op_q == OP_RLC): a_nxt = {a_q[14:0], c_q};
          default:          a_nxt = a_q;
        endcase
        if (abort_req)
          state_nxt = IDLE;
        else if (cnt_q == CNT_W'(1))
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 16'h0000;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
    end else begin
      state_q <= state_nxt;
      a_q     <= a_nxt;
      c_q     <= c_nxt;
      cnt_q   <= cnt_nxt;
      op_q    <= op_nxt;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign shift_out = a_q;
  assign c_out     = c_q;

endmodule

// File: tb/tb_stump_shift_left_iter.sv
// Scoreboard bench for stump_shift_left_iter: directed cases plus
// random ops against a rotate/shift arithmetic model.
module tb_stump_shift_left_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] operand_A;
  logic        c_in;
  logic [1:0]  shift_op;
  logic [3:0]  shift_count;
  logic        busy;
  logic        done;
  logic [15:0] shift_out;
  logic        c_out;

  stump_shift_left_iter #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef STUMP_SHIFT_ABORT_EN
    .abort       (abort),
`endif
    .operand_A   (operand_A),
    .c_in        (c_in),
    .shift_op    (shift_op),
    .shift_count (shift_count),
    .busy        (busy),
    .done        (done),
    .shift_out   (shift_out),
    .c_out       (c_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        c;
    int          cyc;
    int          nbusy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   bcnt   = 0;
  int   dcnt   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: whole-operation shift/rotate arithmetic, not stepwise
  function automatic logic [16:0] model(input logic [1:0] op,
                                        input logic [15:0] a,
                                        input logic ci,
                                        input int n);
    logic [31:0] t;
    logic [33:0] w;
    logic [16:0] v;
    int eff;
    eff = (op == 2'b00) ? 0 : n;
    if (eff == 0) return {1'b0, a};
    case (op)
      2'b01: begin
        t = {16'h0, a} << eff;
        return {t[16], t[15:0]};
      end
      2'b10: begin
        t = {a, a} << eff;
        return {t[16], t[31:16]};
      end
      default: begin
        v = {ci, a};
        w = {v, v} << eff;
        return w[33:17];
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1, expected none");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("shift_out", int'(shift_out), int'(e.res));
          chk("c_out", int'(c_out), int'(e.c));
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", bcnt, e.nbusy);
        end
      end
      if (!busy && !done) bcnt = 0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] a,
                       input logic ci, input logic [3:0] n,
                       input logic [15:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    start       = 1'b1;
    shift_op    = op;
    operand_A   = a;
    c_in        = ci;
    shift_count = n;
    e.res   = er;
    e.c     = ec;
    e.nbusy = (op == 2'b00) ? 0 : int'(n);
    e.cyc   = cyc + 1 + e.nbusy;
    q.push_back(e);
    @(negedge clk);
    start       = 1'b0;
    operand_A   = 16'($urandom);
    c_in        = 1'($urandom);
    shift_op    = 2'($urandom);
    shift_count = 4'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL timeout: got %0d pending, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [16:0] m;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    operand_A = 16'h0;
    c_in = 1'b0;
    shift_op = 2'b00;
    shift_count = 4'h0;
    @(negedge clk);
    chk("rst_shift_out", int'(shift_out), 0);
    chk("rst_c_out", int'(c_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b01, 16'h8001, 1'b0, 4'd1, 16'h0002, 1'b1);
    wait_idle();
    issue(2'b10, 16'h8421, 1'b0, 4'd4, 16'h4218, 1'b0);
    wait_idle();
    issue(2'b11, 16'h0001, 1'b1, 4'd15, 16'hC000, 1'b0);
    wait_idle();
    issue(2'b00, 16'h1234, 1'b1, 4'd7, 16'h1234, 1'b0);
    wait_idle();
    issue(2'b10, 16'hBEEF, 1'b1, 4'd0, 16'hBEEF, 1'b0);
    wait_idle();

    // second start while shifting must be dropped
    issue(2'b10, 16'h8421, 1'b0, 4'd4, 16'h4218, 1'b0);
    start = 1'b1;
    shift_op = 2'b01;
    operand_A = 16'hFFFF;
    shift_count = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // reset mid-shift aborts without done
    issue(2'b01, 16'hFFFF, 1'b1, 4'd10, 16'h0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_shift_out", int'(shift_out), 0);
    chk("mid_rst_c_out", int'(c_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    q.delete();
    d0 = dcnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_rst_no_done", dcnt, d0);

`ifdef STUMP_SHIFT_ABORT_EN
    @(negedge clk);
    start = 1'b1;
    shift_op = 2'b01;
    operand_A = 16'h0001;
    c_in = 1'b0;
    shift_count = 4'd8;
    d0 = dcnt;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_shift_out", int'(shift_out), 16'h0004);
    repeat (12) @(negedge clk);
    chk("abort_no_done", dcnt, d0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [15:0] a;
      logic        ci;
      logic [3:0]  n;
      op = 2'($urandom);
      a  = 16'($urandom);
      ci = 1'($urandom);
      n  = 4'($urandom_range(0, 15));
      m  = model(op, a, ci, int'(n));
      issue(op, a, ci, n, m[15:0], m[16]);
      wait_idle();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/stump_shift_left_iter.md
STUMP_SHIFT_LEFT_ITER -- requirements
Module: stump_shift_left_iter

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 4, the width of shift_count; the maximum shift is 2^CNT_W-1.
REQ-002 Port clk, input, 1, the single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port rst, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-004 Port start, input, 1, request pulse; it SHALL be sampled only in IDLE.
REQ-005 Port operand_A, input, 16, the value to shift; it SHALL be captured on an accepted start.
REQ-006 Port c_in, input, 1, carry-in; it SHALL be captured on an accepted start and used by RLC.
REQ-007 Port shift_op, input, 2, operation code: 00 none, 01 LSL, 10 ROL, 11 RLC; it SHALL be captured on an accepted start.
REQ-008 Port shift_count, input, CNT_W, the number of 1-bit steps; it SHALL be captured on an accepted start.
REQ-009 Port busy, output, 1, SHALL be high while in state SHIFT.
REQ-010 Port done, output, 1, SHALL be a single-cycle pulse that marks a valid result.
REQ-011 Port shift_out, output, 16, the result register.
REQ-012 Port c_out, output, 1, the carry result register.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 SHALL load the working registers and the remaining count; the next state SHALL be SHIFT if the count is nonzero and op is not 00, otherwise DONE.
REQ-015 Each SHIFT cycle SHALL apply one 1-bit step and decrement the remaining count; on the step that brings the count to 0 the FSM SHALL enter DONE.
REQ-016 An LSL step SHALL set c = A[15] and A = {A[14:0], 0}.
REQ-017 A ROL step SHALL set c = A[15] and A = {A[14:0], A[15]}.
REQ-018 An RLC step SHALL set c = A[15] and A = {A[14:0], c}, forming a 17-bit rotate through carry seeded with c_in.
REQ-019 For op 00, or for count 0, the block SHALL return shift_out = operand_A and c_out = 0.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-021 Latency: done SHALL be high in the cycle after N+1 rising edges following the start edge (N = effective count, 0 for op 00).
REQ-022 shift_out and c_out SHALL hold the last result until the next accepted start, and SHALL be valid whenever done=1.
REQ-023 A start asserted in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 Input changes after an accepted start SHALL NOT affect the operation in progress.

Reset
REQ-025 When rst=1 the state SHALL go to IDLE immediately, regardless of clk.
REQ-026 Reset SHALL drive busy=0, done=0, shift_out=16'h0000, c_out=0 and the remaining count to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-028 The macro STUMP_SHIFT_ABORT_EN SHALL control an abort feature.
REQ-029 With STUMP_SHIFT_ABORT_EN defined:
- the block SHALL add an input port abort (1 bit), synchronous to clk;
- abort=1 in SHIFT SHALL return the FSM to IDLE on the next edge with no done pulse;
- shift_out and c_out SHALL be left holding the partially shifted values.
REQ-030 With STUMP_SHIFT_ABORT_EN undefined, the abort port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Bench SHALL check: op=01, A=16'h8001, count=1, c_in=0 -> done 2 cycles after start; shift_out=16'h0002, c_out=1; busy high for 1 cycle.
REQ-032 Bench SHALL check: op=10, A=16'h8421, count=4 -> shift_out=16'h4218, c_out=0; busy high for 4 cycles.
REQ-033 Bench SHALL check: op=11, A=16'h0001, c_in=1, count=15 -> shift_out=16'hC000, c_out=0 (17-bit rotate).
REQ-034 Bench SHALL check: op=00, A=16'h1234, count=7 -> done 1 cycle after start; shift_out=16'h1234, c_out=0; busy never high.
REQ-035 Bench SHALL check: second start during SHIFT is ignored, and rst pulsed mid-SHIFT -> outputs 0 at once, IDLE, no done.
REQ-036 With STUMP_SHIFT_ABORT_EN defined, bench SHALL check: abort in 2nd SHIFT cycle of op=01, A=16'h0001, count=8 -> IDLE; no done; shift_out=16'h0004.
